// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder sequencer.
// The ovf signal exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;

  modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add sequencer: one full-adder slice reused across WIDTH cycles
// to produce {cout,sum} = a + b + cin, with a start/busy/done handshake.
// Optional feature macro: SERIAL_ADDER_OVF_EN (adds the signed overflow flag ovf).
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             load_c;
  logic             shift_c;
  logic             last_c;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] s_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic             x_c;
  logic             y_c;
  logic             s_c;
  logic             c_c;
  logic [WIDTH-1:0] s_next_c;

  // Shared full-adder slice and the sum register value after this bit
  always_comb begin
    x_c      = a_sr[0];
    y_c      = b_sr[0];
    s_c      = x_c ^ y_c ^ carry;
    c_c      = (x_c & y_c) | (carry & (x_c ^ y_c));
    s_next_c = {s_c, s_sr[WIDTH-1:1]};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath strobes
  always_comb begin
    state_d = state_q;
    load_c  = 1'b0;
    shift_c = 1'b0;
    last_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load_c  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        shift_c = 1'b1;
        if (cnt == CNT_LAST) begin
          last_c  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        // A start seen here is taken immediately, giving back-to-back adds
        if (bus.start) begin
          load_c  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand/sum shift registers, carry flop and bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      s_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (load_c) begin
      a_sr  <= bus.a;
      b_sr  <= bus.b;
      s_sr  <= '0;
      carry <= bus.cin;
      cnt   <= '0;
    end else if (shift_c) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      s_sr  <= s_next_c;
      carry <= c_c;
      // Counter parks on the last bit index rather than wrapping
      if (!last_c) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Registered handshake outputs, derived from the upcoming state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_d == RUN);
      done_q <= (state_d == DONE);
    end
  end

  // Result registers, updated only on the final bit and held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (last_c) begin
      sum_q  <= s_next_c;
      cout_q <= c_c;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q;

  // Signed overflow: carry into the MSB xor carry out of the MSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (last_c) begin
      ovf_q <= carry ^ c_c;
    end
  end

  assign bus.ovf = ovf_q;
`endif

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WIDTH=4): random and exhaustive adds
// checked against an arithmetic reference model. Honours SERIAL_ADDER_OVF_EN.
module tb_serial_adder_ctrl;

  localparam int unsigned WIDTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder_if #(.WIDTH(WIDTH)) bus ();

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    int               done_cyc;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain unsigned and signed integer arithmetic
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input int done_cyc);
    exp_t e;
    int total;
    int sa;
    int sbv;
    int r;
    total = int'(a) + int'(b) + int'(cin);
    sa    = a[WIDTH-1] ? int'(a) - (1 << WIDTH) : int'(a);
    sbv   = b[WIDTH-1] ? int'(b) - (1 << WIDTH) : int'(b);
    r     = sa + sbv + int'(cin);
    e.sum      = WIDTH'(total % (1 << WIDTH));
    e.cout     = ((total >> WIDTH) & 1) != 0;
    e.ovf      = (r > (1 << (WIDTH - 1)) - 1) || (r < -(1 << (WIDTH - 1)));
    e.done_cyc = done_cyc;
    return e;
  endfunction

  // Monitor: pops the scoreboard on every done pulse, checks hold behaviour otherwise
  logic [WIDTH:0] hold     = '0;
  logic           hold_ovf = 1'b0;
  int             busy_run = 0;
  logic           prev_done = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      hold      = '0;
      hold_ovf  = 1'b0;
      busy_run  = 0;
      prev_done = 1'b0;
    end else begin
      if (bus.done) begin
        chk("done_single_cycle", 32'(prev_done), 32'(0));
        chk("busy_length", 32'(busy_run), 32'(WIDTH));
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_done: got done=1 expected no pending add (t=%0t)", $time);
          hold = {bus.cout, bus.sum};
        end else begin
          e = sb.pop_front();
          chk("sum", 32'(bus.sum), 32'(e.sum));
          chk("cout", 32'(bus.cout), 32'(e.cout));
          chk("latency", 32'(cyc), 32'(e.done_cyc));
`ifdef SERIAL_ADDER_OVF_EN
          chk("ovf", 32'(bus.ovf), 32'(e.ovf));
`endif
          hold     = {e.cout, e.sum};
          hold_ovf = e.ovf;
        end
        busy_run = 0;
      end else begin
        chk("result_hold", 32'({bus.cout, bus.sum}), 32'(hold));
`ifdef SERIAL_ADDER_OVF_EN
        chk("ovf_hold", 32'(bus.ovf), 32'(hold_ovf));
`endif
      end
      if (bus.busy) busy_run++;
      prev_done = bus.done;
    end
  end

  // Called at posedge+1; issues one add once the DUT can accept it
  task automatic do_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.busy !== 1'b0) begin
      chk("wait_not_busy", 32'(bus.busy), 32'(0));
    end
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    bus.start = 1'b1;
    sb.push_back(model(a, b, cin, cyc + 1 + int'(WIDTH)));
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a     = WIDTH'($urandom);
    bus.b     = WIDTH'($urandom);
    bus.cin   = 1'($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 32'(0));
    chk({tag, "_done"}, 32'(bus.done), 32'(0));
    chk({tag, "_sum"},  32'(bus.sum),  32'(0));
    chk({tag, "_cout"}, 32'(bus.cout), 32'(0));
`ifdef SERIAL_ADDER_OVF_EN
    chk({tag, "_ovf"},  32'(bus.ovf),  32'(0));
`endif
  endtask

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish before %0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    int n;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    rst_n     = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single add, latency and busy length checked by the monitor
    do_add(4'h1, 4'h0, 1'b0);

    // Spot checks including wrap and overflow corners
    do_add(4'hF, 4'h1, 1'b0);
    do_add(4'hF, 4'hF, 1'b1);
    do_add(4'h7, 4'h1, 1'b0);
    do_add(4'h8, 4'h8, 1'b0);

    // Exhaustive operands with occasional idle gaps
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        for (int c = 0; c < 2; c++) begin
          do_add(WIDTH'(i), WIDTH'(j), 1'(c));
          if ($urandom_range(3) == 0) begin
            @(posedge clk); #1;
          end
        end
      end
    end

    // Start pulsed mid-run with zeroed operands must be ignored
    do_add(4'h5, 4'h6, 1'b1);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;

    // Asynchronous reset in the middle of a run
    do_add(4'h9, 4'h9, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrun_reset");
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    do_add(4'h3, 4'h4, 1'b0);

    // Start held high: each edge with busy low accepts the operands present then
    @(posedge clk); #1;
    bus.start = 1'b1;
    for (int k = 0; k < 40; k++) begin
      bus.a   = WIDTH'($urandom);
      bus.b   = WIDTH'($urandom);
      bus.cin = 1'($urandom);
      if (bus.busy === 1'b0) begin
        sb.push_back(model(bus.a, bus.b, bus.cin, cyc + 1 + int'(WIDTH)));
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;

    // Random adds with random gaps
    for (int k = 0; k < 60; k++) begin
      do_add(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
      repeat ($urandom_range(2)) begin
        @(posedge clk); #1;
      end
    end

    // Drain the scoreboard
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_pending", 32'(sb.size()), 32'(0));
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
